// File: rtl/grf_pkg.sv
// rtl/grf_pkg.sv - shared GRF geometry and scan state encoding for the GRF scanner
package grf_pkg;
  localparam int GRF_ADDR_W = 5;
  localparam int GRF_DATA_W = 32;
  localparam int GRF_LAST   = 31;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;
endpackage

// File: rtl/grf_scan_outreg.sv
// rtl/grf_scan_outreg.sv - single-entry valid/ready holding register for {addr,data} pairs
module grf_scan_outreg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready,
  output logic              load,
  output logic              fire,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // A held pair may be replaced in the same cycle it is accepted, giving full throughput.
  assign load = fill & (~valid | ready);
  assign fire = valid & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/grf_scanner.sv
// rtl/grf_scanner.sv - walks GRF read port 2 and streams {addr,data} pairs
// Optional running XOR of emitted data enabled by GRF_SCAN_CHECKSUM_EN.
module grf_scanner
  import grf_pkg::*;
#(
  parameter int ADDR_W    = GRF_ADDR_W,
  parameter int DATA_W    = GRF_DATA_W,
  parameter int LAST_ADDR = GRF_LAST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] GRF_RAddr,
  input  logic [DATA_W-1:0] GRF_RData,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W-1:0] Out_Addr,
  output logic [DATA_W-1:0] Out_Data,
  output logic [DATA_W-1:0] Out_Sum
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  scan_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic              load;
  logic              fire;
  logic              start_acc;

  assign GRF_RAddr = ptr;
  // Start coinciding with the Done pulse must not launch a new scan.
  assign start_acc = (state == IDLE) && Start && !Done;

  grf_scan_outreg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_outreg (
    .clk    (clk),
    .reset  (reset),
    .fill   (state == SCAN),
    .in_addr(ptr),
    .in_data(GRF_RData),
    .ready  (Out_Ready),
    .load   (load),
    .fire   (fire),
    .valid  (Out_Valid),
    .addr   (Out_Addr),
    .data   (Out_Data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            state <= SCAN;
            Busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (load) begin
            if (ptr == LAST) state <= DRAIN;
            else ptr <= ptr + 1'b1;
          end
        end
        DRAIN: begin
          if (fire) begin
            state <= IDLE;
            ptr   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GRF_SCAN_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset) sum <= '0;
    else if (start_acc) sum <= '0;
    else if (fire) sum <= sum ^ Out_Data;
  end

  assign Out_Sum = sum;
`else
  assign Out_Sum = '0;
`endif

endmodule

// File: tb/tb_grf_scanner.sv
// tb/tb_grf_scanner.sv - directed self-checking bench for grf_scanner
module tb_grf_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic        Busy, Done, Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [4:0]  GRF_RAddr, Out_Addr;
  logic [31:0] GRF_RData, Out_Data, Out_Sum;

  logic [31:0] grf [32];
  logic        pre = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] expd [32];
  logic [31:0] msum = 32'd0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign GRF_RData = grf[GRF_RAddr];

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 32; i++) grf[i] <= i * 3;
    end else if (wr_en) begin
      grf[5] <= 32'd3411;
    end
  end

  grf_scanner dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .Busy     (Busy),
    .Done     (Done),
    .GRF_RAddr(GRF_RAddr),
    .GRF_RData(GRF_RData),
    .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready),
    .Out_Addr (Out_Addr),
    .Out_Data (Out_Data),
    .Out_Sum  (Out_Sum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, Done}, 32'd0);
    chk({tag, "_valid"}, {31'd0, Out_Valid}, 32'd0);
    chk({tag, "_addr"}, {27'd0, Out_Addr}, 32'd0);
    chk({tag, "_data"}, Out_Data, 32'd0);
    chk({tag, "_sum"}, Out_Sum, 32'd0);
    chk({tag, "_raddr"}, {27'd0, GRF_RAddr}, 32'd0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    msum = 32'd0;
    chk("start_busy", {31'd0, Busy}, 32'd1);
    chk("start_valid", {31'd0, Out_Valid}, 32'd0);
    chk("start_sum", Out_Sum, 32'd0);
  endtask

  // mode 0: ready always high, mode 1: ready pattern 1,0,0,1
  // opt 1: Start at pair 10 and in Done cycle, 2: reset at pair 12, 3: write $5 while loading
  task automatic run_scan(input int mode, input int opt);
    int n = 0;
    int dones = 0;
    int last_acc = -1;
    int done_cyc = -1;
    int cyc;
    logic stall = 1'b0;
    logic [4:0] pa = '0;
    logic [31:0] pd = '0;
    bit restarted = 0;
    bit wrote = 0;
    bit aborted = 0;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      Start = 1'b0;
      wr_en = 1'b0;
      if (cyc == 0) chk("first_valid", {31'd0, Out_Valid}, 32'd1);
      if (stall) begin
        chk("stall_valid", {31'd0, Out_Valid}, 32'd1);
        chk("stall_addr", {27'd0, Out_Addr}, {27'd0, pa});
        chk("stall_data", Out_Data, pd);
      end
      chk("run_sum", Out_Sum, msum);
      if (Done) begin
        dones++;
        done_cyc = cyc;
        chk("done_busy", {31'd0, Busy}, 32'd0);
        chk("done_sum", Out_Sum, msum);
        if (opt == 1) Start = 1'b1;
        break;
      end
      if (opt == 2 && Out_Valid && Out_Addr == 5'd12) begin
        reset = 1'b1;
        aborted = 1;
        break;
      end
      if (opt == 3 && !wrote && Busy && GRF_RAddr == 5'd5) begin
        wr_en = 1'b1;
        wrote = 1;
      end
      if (opt == 1 && !restarted && n == 10) begin
        Start = 1'b1;
        restarted = 1;
      end
      Out_Ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      stall = Out_Valid && !Out_Ready;
      pa = Out_Addr;
      pd = Out_Data;
      if (Out_Valid && Out_Ready) begin
        chk("pair_addr", {27'd0, Out_Addr}, n);
        chk("pair_data", Out_Data, expd[n & 31]);
        if (mode == 0) chk("pair_cycle", cyc, n);
`ifdef GRF_SCAN_CHECKSUM_EN
        msum = msum ^ expd[n & 31];
`endif
        last_acc = cyc;
        n++;
      end
    end
    if (aborted) begin
      @(negedge clk);
      reset = 1'b0;
      msum = 32'd0;
      chk_idle("abort");
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", {31'd0, Done}, 32'd0);
      end
    end else begin
      chk("timeout", {31'd0, (dones == 1)}, 32'd1);
      chk("pair_count", n, 32);
      chk("done_latency", done_cyc, last_acc + 1);
      @(negedge clk);
      Start = 1'b0;
      Out_Ready = 1'b1;
      chk("post_busy", {31'd0, Busy}, 32'd0);
      chk("post_done", {31'd0, Done}, 32'd0);
      chk("post_raddr", {27'd0, GRF_RAddr}, 32'd0);
      chk("post_sum", Out_Sum, msum);
      repeat (2) @(negedge clk);
      chk("idle_valid", {31'd0, Out_Valid}, 32'd0);
      chk("idle_busy", {31'd0, Busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] xsum;
    xsum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      expd[i] = i * 3;
      xsum = xsum ^ (i * 3);
    end

    reset = 1'b1;
    pre = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pre = 1'b0;
    chk_idle("reset");

    // full-rate scan, then checksum against a directly computed XOR
    start_pulse();
    run_scan(0, 0);
`ifdef GRF_SCAN_CHECKSUM_EN
    chk("xor_total", Out_Sum, xsum);
`else
    chk("xor_total", Out_Sum, 32'd0);
`endif

    start_pulse();
    run_scan(1, 0);

    start_pulse();
    run_scan(0, 1);

    start_pulse();
    run_scan(0, 2);
    start_pulse();
    run_scan(0, 0);

    start_pulse();
    run_scan(0, 3);
    expd[5] = 32'd3411;
    start_pulse();
    run_scan(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
